// File: rtl/mmio_bridge.sv
// mmio_bridge: registered, stall-based bridge from the CPU data-memory stage
// to NUM_SLV memory-mapped peripherals. Internal accesses pass straight through;
// external accesses are decoded, strobed until the selected slave acks, and the
// pipeline is stalled meanwhile.
// Optional feature: define MMIO_TIMEOUT_EN to add an 8-bit BUSY watchdog that
// completes with an error after TIMEOUT cycles without an ack.
module mmio_bridge #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int EXT_BITS = 3,
    parameter int NUM_SLV  = 4,
    parameter int SEL_LSB  = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic                        cpu_re,
    input  logic                        cpu_we,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic                        cpu_ext,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        stall,
    output logic [ADDR_W-1:0]           mm_addr,
    output logic [DATA_W-1:0]           mm_wdata,
    output logic                        mm_re,
    output logic                        mm_we,
    output logic [NUM_SLV-1:0]          mm_sel,
    input  logic [NUM_SLV*DATA_W-1:0]   mm_rdata,
    input  logic [NUM_SLV-1:0]          mm_ack,
    output logic                        err,
    output logic [ADDR_W-1:0]           err_addr,
    input  logic                        err_clr
);

    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [SW:0] NumSlvW = (SW+1)'(NUM_SLV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject parameter sets the slot decode and watchdog cannot represent.
    if (NUM_SLV < 1 || NUM_SLV > 16) begin : gBadNumSlv
        $error("mmio_bridge: NUM_SLV must be within 1..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
        $error("mmio_bridge: TIMEOUT must be within 1..255");
    end

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic [NUM_SLV-1:0]  sel_q, sel_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   errAddr_q, errAddr_d;

    logic                cpuExt;
    logic                inRange;
    logic                ackHit;
    logic                errSet;
    logic [SW-1:0]       slvIdx;
    logic [NUM_SLV-1:0]  idxOh;
    logic [DATA_W-1:0]   ackData;

`ifdef MMIO_TIMEOUT_EN
    localparam logic [7:0] TimeoutW = 8'(TIMEOUT);
    logic [7:0]          cnt_q, cnt_d;
`else
    // No watchdog storage: BUSY waits for the slave ack indefinitely.
`endif

    assign cpuExt  = (|cpu_addr[ADDR_W-1 -: EXT_BITS]) & (cpu_re | cpu_we);
    assign slvIdx  = cpu_addr[SEL_LSB +: SW];
    assign inRange = ({1'b0, slvIdx} < NumSlvW);
    assign ackHit  = |(mm_ack & sel_q);

    // Turn the slave-index field into the one-hot select launched on entry to BUSY.
    always_comb begin
        idxOh = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slvIdx == SW'(i)) begin
                idxOh[i] = 1'b1;
            end
        end
    end

    // Pick the read-data slot of the currently selected slave.
    always_comb begin
        ackData = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                ackData = ackData | mm_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: launch, wait for ack (or watchdog), then one DONE cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        re_d      = re_q;
        we_d      = we_q;
        sel_d     = sel_q;
        errAddr_d = errAddr_q;
        errSet    = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpuExt) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (inRange) begin
                        state_d = S_BUSY;
                        we_d    = cpu_we;
                        re_d    = ~cpu_we;
                        sel_d   = idxOh;
`ifdef MMIO_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d   = S_DONE;
                        rdata_d   = '1;
                        errSet    = 1'b1;
                        errAddr_d = cpu_addr;
                    end
                end
            end
            S_BUSY: begin
                if (ackHit) begin
                    state_d = S_DONE;
                    if (re_q) begin
                        rdata_d = ackData;
                    end
                    re_d  = 1'b0;
                    we_d  = 1'b0;
                    sel_d = '0;
                end else begin
`ifdef MMIO_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TimeoutW) begin
                        state_d   = S_DONE;
                        rdata_d   = '1;
                        errSet    = 1'b1;
                        errAddr_d = addr_q;
                        re_d      = 1'b0;
                        we_d      = 1'b0;
                        sel_d     = '0;
                    end
`else
                    state_d = S_BUSY;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                re_d    = 1'b0;
                we_d    = 1'b0;
                sel_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                re_d    = 1'b0;
                we_d    = 1'b0;
                sel_d   = '0;
            end
        endcase
        err_d = errSet | (err_q & ~err_clr);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            err_q     <= 1'b0;
            errAddr_q <= '0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            errAddr_q <= errAddr_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign cpu_ext   = cpuExt;
    assign stall     = ((state_q == S_IDLE) & cpuExt) | (state_q == S_BUSY);
    assign cpu_rdata = rdata_q;
    assign mm_addr   = addr_q;
    assign mm_wdata  = wdata_q;
    assign mm_re     = re_q;
    assign mm_we     = we_q;
    assign mm_sel    = sel_q;
    assign err       = err_q;
    assign err_addr  = errAddr_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed scoreboard bench for mmio_bridge with three slots,
// so slot index 3 exercises the out-of-range error path.
module tb_mmio_bridge;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NS = 3;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     cpu_addr;
    logic              cpu_re;
    logic              cpu_we;
    logic [DW-1:0]     cpu_wdata;
    logic              cpu_ext;
    logic [DW-1:0]     cpu_rdata;
    logic              stall;
    logic [AW-1:0]     mm_addr;
    logic [DW-1:0]     mm_wdata;
    logic              mm_re;
    logic              mm_we;
    logic [NS-1:0]     mm_sel;
    logic [NS*DW-1:0]  mm_rdata;
    logic [NS-1:0]     mm_ack;
    logic              err;
    logic [AW-1:0]     err_addr;
    logic              err_clr;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] addr;
        logic        isWrite;
        logic [15:0] wdata;
        logic [2:0]  sel;
        logic [15:0] rdata;
        logic        err;
        logic [15:0] errAddr;
        int          stalls;
    } expT;

    expT expQ[$];

    mmio_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .EXT_BITS(3), .NUM_SLV(NS), .SEL_LSB(8), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_ext(cpu_ext), .cpu_rdata(cpu_rdata), .stall(stall),
        .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_re(mm_re), .mm_we(mm_we),
        .mm_sel(mm_sel), .mm_rdata(mm_rdata), .mm_ack(mm_ack),
        .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one external access; expected response goes to the scoreboard.
    // busyLen is the number of BUSY cycles the slave takes (ack in the last one).
    task automatic applyStimulus(input logic [15:0] addr, input logic isWrite,
                                 input logic [15:0] wdata, input int busyLen,
                                 input int ackSlot, input int earlySlot, input logic clrDuring,
                                 input logic [2:0] expSel, input logic [15:0] expRdata,
                                 input logic expErr, input logic [15:0] expErrAddr);
        expT e;
        logic [2:0] ack;
        e.addr = addr; e.isWrite = isWrite; e.wdata = wdata; e.sel = expSel;
        e.rdata = expRdata; e.err = expErr; e.errAddr = expErrAddr; e.stalls = busyLen + 1;
        expQ.push_back(e);
        cpu_addr  = addr;
        cpu_we    = isWrite;
        cpu_re    = ~isWrite;
        cpu_wdata = wdata;
        err_clr   = clrDuring;
        @(posedge clk); #1;
        err_clr = 1'b0;
        for (int k = 0; k < busyLen; k++) begin
            ack = '0;
            if (k == 0 && earlySlot >= 0) ack[earlySlot] = 1'b1;
            if (k == busyLen - 1 && ackSlot >= 0) ack[ackSlot] = 1'b1;
            mm_ack = ack;
            @(posedge clk); #1;
        end
        mm_ack = '0;
        @(posedge clk); #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    // Monitor: count stall cycles, capture the strobes, and score each DONE cycle.
    initial begin
        int          stallCnt;
        logic        seenAny, seenRe, seenWe, unstable;
        logic [2:0]  seenSel;
        logic [15:0] seenAddr, seenWdata;
        expT         e;
        stallCnt = 0; seenAny = 0; seenRe = 0; seenWe = 0; unstable = 0;
        seenSel = '0; seenAddr = '0; seenWdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stallCnt = 0; seenAny = 0; seenRe = 0; seenWe = 0; unstable = 0; seenSel = '0;
            end else if (stall) begin
                stallCnt++;
                if (mm_sel != '0 || mm_re || mm_we) begin
                    if (!seenAny) begin
                        seenAny = 1; seenSel = mm_sel; seenRe = mm_re; seenWe = mm_we;
                        seenAddr = mm_addr; seenWdata = mm_wdata;
                    end else if (mm_sel != seenSel || mm_re != seenRe || mm_we != seenWe ||
                                 mm_addr != seenAddr || mm_wdata != seenWdata) begin
                        unstable = 1;
                    end
                end
            end else if (cpu_ext) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected completion: got addr 0x%0h expected no access", cpu_addr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("stall cycles", stallCnt, e.stalls);
                    checkOutput("cpu_rdata", cpu_rdata, e.rdata);
                    checkOutput("err", err, e.err);
                    checkOutput("err_addr", err_addr, e.errAddr);
                    checkOutput("mm_sel seen", seenSel, e.sel);
                    checkOutput("mm_we seen", seenWe, (e.sel != 0) && e.isWrite);
                    checkOutput("mm_re seen", seenRe, (e.sel != 0) && !e.isWrite);
                    checkOutput("strobes stable", unstable, 0);
                    checkOutput("strobes low in DONE", {mm_sel, mm_re, mm_we}, 0);
                    if (e.sel != 0) checkOutput("mm_addr seen", seenAddr, e.addr);
                    if (e.sel != 0 && e.isWrite) checkOutput("mm_wdata seen", seenWdata, e.wdata);
                end
                stallCnt = 0; seenAny = 0; seenRe = 0; seenWe = 0; unstable = 0; seenSel = '0;
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; cpu_addr = '0; cpu_re = 0; cpu_we = 0; cpu_wdata = '0;
        mm_ack = '0; err_clr = 0;
        mm_rdata = {16'h2222, 16'hBEEF, 16'h1111};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset stall", stall, 0);
        checkOutput("reset mm_re/mm_we", {mm_re, mm_we}, 0);
        checkOutput("reset mm_sel", mm_sel, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset mm_addr", mm_addr, 0);
        checkOutput("reset mm_wdata", mm_wdata, 0);
        checkOutput("reset cpu_rdata", cpu_rdata, 0);
        checkOutput("reset err_addr", err_addr, 0);

        // Internal read stays in IDLE with no stall.
        @(posedge clk); #1;
        cpu_addr = 16'h0100; cpu_re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("internal cpu_ext", cpu_ext, 0);
            checkOutput("internal stall", stall, 0);
            checkOutput("internal mm_re", mm_re, 0);
        end
        @(posedge clk); #1;
        cpu_re = 1'b0;

        // Zero-wait read from slot 1.
        applyStimulus(16'hC104, 0, 16'h0000, 1, 1, -1, 0, 3'b010, 16'hBEEF, 0, 16'h0000);
        // Write to slot 2, ack in 4th BUSY cycle, slot 0 acks early.
        applyStimulus(16'hC200, 1, 16'h1234, 4, 2, 0, 0, 3'b100, 16'hBEEF, 0, 16'h0000);
        // Slot 3 does not exist with three slots.
        applyStimulus(16'hC300, 0, 16'h0000, 0, -1, -1, 0, 3'b000, 16'hFFFF, 1, 16'hC300);

        // err_clr pulse clears the sticky error, address is kept.
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err after clr", err, 0);
        checkOutput("err_addr after clr", err_addr, 16'hC300);
        @(posedge clk); #1;

        // New error in the same cycle as err_clr: set wins.
        applyStimulus(16'hC380, 0, 16'h0000, 0, -1, -1, 1, 3'b000, 16'hFFFF, 1, 16'hC380);
        // Back-to-back reads, slot 0 then slot 2 (0x2204 is external via bit 13).
        applyStimulus(16'hE000, 0, 16'h0000, 1, 0, -1, 0, 3'b001, 16'h1111, 1, 16'hC380);
        applyStimulus(16'h2204, 0, 16'h0000, 2, 2, -1, 0, 3'b100, 16'h2222, 1, 16'hC380);

`ifdef MMIO_TIMEOUT_EN
        // Silent slave: watchdog ends the access after 15 BUSY cycles.
        applyStimulus(16'hC104, 0, 16'h0000, 15, -1, -1, 0, 3'b010, 16'hFFFF, 1, 16'hC104);
`else
        // Slow slave: stall holds for over 100 cycles until the ack.
        applyStimulus(16'hC104, 0, 16'h0000, 110, 1, -1, 0, 3'b010, 16'hBEEF, 1, 16'hC380);
`endif

        // Reset in the middle of BUSY abandons the access.
        cpu_addr = 16'hC000; cpu_re = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; cpu_re = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid-BUSY reset stall", stall, 0);
        checkOutput("mid-BUSY reset mm_re", mm_re, 0);
        checkOutput("mid-BUSY reset mm_sel", mm_sel, 0);
        checkOutput("mid-BUSY reset err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
